// File: rtl/utopia1_atm_tx_pkg.sv
// -----------------------------------------------------------------------------
// utopia1_atm_tx_pkg
// Definitions shared by the UTOPIA level-1 transmit and receive sides:
//   - uniType / nniType : 424-bit ATM cell layouts. Fields are declared MSB
//     first, so octet k of the cell on the wire is bits [423-8k -: 8].
//   - CELL_OCTETS / HDR_OCTETS / PAYLOAD_OCTETS : cell geometry.
//   - HEC_POLY / HEC_COSET : HEC CRC-8 generator (x^8+x^2+x+1) and coset.
// -----------------------------------------------------------------------------
package utopia1_atm_tx_pkg;

  localparam int CELL_OCTETS    = 53;
  localparam int HDR_OCTETS     = 5;
  localparam int PAYLOAD_OCTETS = 48;
  localparam int CELL_BITS      = CELL_OCTETS * 8;

  localparam logic [7:0] HEC_POLY  = 8'h07;
  localparam logic [7:0] HEC_COSET = 8'h55;

  // User-network interface cell.
  typedef struct packed {
    logic [3:0]                           GFC;
    logic [7:0]                           VPI;
    logic [15:0]                          VCI;
    logic                                 CLP;
    logic [2:0]                           PT;
    logic [7:0]                           HEC;
    logic [0:PAYLOAD_OCTETS-1][7:0]       Payload;
  } uniType;

  // Network-network interface cell (GFC bits become part of the VPI).
  typedef struct packed {
    logic [11:0]                          VPI;
    logic [15:0]                          VCI;
    logic                                 CLP;
    logic [2:0]                           PT;
    logic [7:0]                           HEC;
    logic [0:PAYLOAD_OCTETS-1][7:0]       Payload;
  } nniType;

endpackage

// File: rtl/atm_hec_gen.sv
// -----------------------------------------------------------------------------
// atm_hec_gen
// Combinational ATM header error control generator. CRC-8 with generator
// x^8+x^2+x+1, initial value 0, processed MSB first over the four header
// octets, result XORed with the coset 0x55.
// Ports:
//   header  in  32  header octets 0..3, octet 0 in bits [31:24]
//   hec     out  8  HEC octet to transmit / compare against
// -----------------------------------------------------------------------------
module atm_hec_gen
  import utopia1_atm_tx_pkg::*;
(
  input  logic [31:0] header,
  output logic [7:0]  hec
);

  logic [7:0] crc;
  logic       fb;

  // Bit-serial LFSR unrolled over all 32 header bits.
  always_comb begin
    crc = 8'h00;
    fb  = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[7] ^ header[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? HEC_POLY : 8'h00);
    end
    hec = crc ^ HEC_COSET;
  end

endmodule

// File: rtl/utopia1_atm_tx.sv
// -----------------------------------------------------------------------------
// utopia1_atm_tx
// Transmit side of a UTOPIA level-1 ATM-layer port. Accepts one cell from the
// switch core over valid/ready, buffers it, and serialises its 53 octets onto
// the PHY-facing bus, advancing only when the PHY asserts clav.
// Parameters:
//   GEN_HEC  1: octet 4 is a freshly computed HEC; 0: HEC field sent as is
// Ports:
//   clk_in    in    1  clock, all logic on its rising edge
//   reset     in    1  asynchronous active-high reset
//   clk_out   out   1  copy of clk_in for the PHY
//   ATMcell   in  424  cell from the core, sampled on the accept edge
//   valid     in    1  core offers ATMcell
//   ready     out   1  block can accept a cell
//   data      out   8  TxData
//   soc       out   1  start of cell, high with octet 0 only
//   en        out   1  TxEnb, active low: data is presented while 0
//   clav      in    1  TxClav: PHY takes the presented octet this edge
//   tx_count  out  16  cells fully transmitted, wraps modulo 2^16
// -----------------------------------------------------------------------------
module utopia1_atm_tx
  import utopia1_atm_tx_pkg::*;
#(
  parameter bit GEN_HEC = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic        clk_out,
  input  uniType      ATMcell,
  input  logic        valid,
  output logic        ready,
  output logic [7:0]  data,
  output logic        soc,
  output logic        en,
  input  logic        clav,
  output logic [15:0] tx_count
);

  localparam logic [5:0] LAST_IDX = 6'(CELL_OCTETS - 1);
  localparam int         HEC_IDX  = HDR_OCTETS - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_reg, state_next;
  uniType      buf_reg;
  logic        buf_load;
  logic [5:0]  idx_reg, idx_next, idx_inc;
  logic [7:0]  data_reg, data_next;
  logic        soc_reg, soc_next;
  logic        en_reg, en_next;
  logic        ready_reg, ready_next;
  logic [15:0] tx_count_reg, tx_count_next;

  logic [7:0]  hec_calc;
  logic [7:0]  octet_arr [64];
  logic        unused_hec_field;

  assign clk_out = clk_in;

  atm_hec_gen u_hec_gen (
    .header (buf_reg[CELL_BITS-1 -: 32]),
    .hec    (hec_calc)
  );

  // Wire the buffer out as an octet table. The table is padded to the full
  // index range so the octet mux never reads outside a declared entry.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_octet
      if (GEN_HEC && gi == HEC_IDX) begin : g_hec
        assign octet_arr[gi] = hec_calc;
      end else if (gi < CELL_OCTETS) begin : g_buf
        assign octet_arr[gi] = buf_reg[CELL_BITS-1-8*gi -: 8];
      end else begin : g_pad
        assign octet_arr[gi] = 8'h00;
      end
    end
  endgenerate

  // The received HEC field is dead when the HEC is regenerated.
  assign unused_hec_field = ^buf_reg.HEC;

  assign idx_inc = idx_reg + 6'd1;

  // Next-state and output-register logic. In SEND en_reg is always 0, so a
  // transfer edge is simply an edge with clav high.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    data_next     = data_reg;
    soc_next      = soc_reg;
    en_next       = en_reg;
    ready_next    = ready_reg;
    tx_count_next = tx_count_reg;
    buf_load      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid) begin
          // Accept edge: octet 0 never carries the HEC, so it can be taken
          // straight from the input rather than the not-yet-loaded buffer.
          buf_load   = 1'b1;
          ready_next = 1'b0;
          data_next  = ATMcell[CELL_BITS-1 -: 8];
          soc_next   = 1'b1;
          en_next    = 1'b0;
          idx_next   = 6'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (clav) begin
          if (idx_reg == LAST_IDX) begin
            en_next       = 1'b1;
            data_next     = 8'h00;
            soc_next      = 1'b0;
            ready_next    = 1'b1;
            tx_count_next = tx_count_reg + 16'd1;
            state_next    = IDLE;
          end else begin
            idx_next  = idx_inc;
            data_next = octet_arr[idx_inc];
            soc_next  = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= 6'd0;
      data_reg     <= 8'h00;
      soc_reg      <= 1'b0;
      en_reg       <= 1'b1;
      ready_reg    <= 1'b1;
      tx_count_reg <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      data_reg     <= data_next;
      soc_reg      <= soc_next;
      en_reg       <= en_next;
      ready_reg    <= ready_next;
      tx_count_reg <= tx_count_next;
    end
  end

  // Cell buffer carries no reset; its contents only matter after an accept.
  always_ff @(posedge clk_in) begin
    if (buf_load) begin
      buf_reg <= ATMcell;
    end
  end

  assign ready    = ready_reg;
  assign data     = data_reg;
  assign soc      = soc_reg;
  assign en       = en_reg;
  assign tx_count = tx_count_reg;

endmodule

// File: tb/tb_utopia1_atm_tx.sv
// -----------------------------------------------------------------------------
// tb_utopia1_atm_tx
// Self-checking bench for utopia1_atm_tx. Expected octets are pushed to a
// queue when a cell is accepted and popped on every PHY transfer. A second
// instance with GEN_HEC=0 runs in lockstep for the pass-through HEC case.
// -----------------------------------------------------------------------------
module tb_utopia1_atm_tx;

  logic         clk_in = 1'b0;
  logic         reset  = 1'b1;
  logic [423:0] ATMcell = '0;
  logic         valid  = 1'b0;
  logic         clav   = 1'b0;

  logic         clk_out, ready, soc, en;
  logic [7:0]   data;
  logic [15:0]  tx_count;
  logic         clk_out0, ready0, soc0, en0;
  logic [7:0]   data0;
  logic [15:0]  tx_count0;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;
  bit acc_flag;

  typedef struct {
    logic [7:0] d;
    logic       s;
  } exp_t;
  exp_t exp_q [$];

  always #20 clk_in = ~clk_in;

  utopia1_atm_tx #(.GEN_HEC(1'b1)) dut (
    .clk_in(clk_in), .reset(reset), .clk_out(clk_out), .ATMcell(ATMcell),
    .valid(valid), .ready(ready), .data(data), .soc(soc), .en(en),
    .clav(clav), .tx_count(tx_count)
  );

  utopia1_atm_tx #(.GEN_HEC(1'b0)) dut0 (
    .clk_in(clk_in), .reset(reset), .clk_out(clk_out0), .ATMcell(ATMcell),
    .valid(valid), .ready(ready0), .data(data0), .soc(soc0), .en(en0),
    .clav(clav), .tx_count(tx_count0)
  );

  // HEC by polynomial long division of {header, 8'h00} by 0x107.
  function automatic logic [7:0] model_hec(input logic [31:0] hdr);
    logic [39:0] r;
    r = {hdr, 8'h00};
    for (int b = 39; b >= 8; b--) begin
      if (r[b]) r[b -: 9] = r[b -: 9] ^ 9'h107;
    end
    return r[7:0] ^ 8'h55;
  endfunction

  function automatic logic [423:0] make_cell(input logic [31:0] hdr,
                                             input logic [7:0] hec_field,
                                             input logic [7:0] pay_base);
    logic [423:0] c;
    c = '0;
    c[423:392] = hdr;
    c[391:384] = hec_field;
    for (int i = 0; i < 48; i++) c[383-8*i -: 8] = pay_base + 8'(i);
    return c;
  endfunction

  task automatic push_cell(input logic [423:0] c);
    exp_t e;
    for (int k = 0; k < 53; k++) begin
      e.d = (k == 4) ? model_hec(c[423:392]) : c[423-8*k -: 8];
      e.s = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  // Advance one clock; a cell offered while ready is high is accepted here.
  task automatic step();
    acc_flag = 1'b0;
    if (ready === 1'b1 && valid === 1'b1 && reset === 1'b0) begin
      push_cell(ATMcell);
      acc_flag = 1'b1;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 1'b0; clav = 1'b0;
    repeat (3) @(posedge clk_in);
    #3 reset = 1'b0;
    @(posedge clk_in); #1;
    checks += 6;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
    if (en !== 1'b1) begin failures++; $display("FAIL reset_en got=%b want=1", en); end
    if (soc !== 1'b0) begin failures++; $display("FAIL reset_soc got=%b want=0", soc); end
    if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", data); end
    if (tx_count !== 16'h0) begin failures++; $display("FAIL reset_tx_count got=%h want=0000", tx_count); end
    if (ready0 !== 1'b1 || en0 !== 1'b1 || clk_out !== clk_in || clk_out0 !== clk_in) begin
      failures++; $display("FAIL reset_misc ready0=%b en0=%b clk_out=%b clk_out0=%b want 1 1 %b %b", ready0, en0, clk_out, clk_out0, clk_in, clk_in);
    end
    $display("reset done ready=%b en=%b tx_count=%0d", ready, en, tx_count);
  endtask

  task automatic test_basic();
    logic [423:0] c;
    exp_t e;
    int en_low = 0, guard = 0;
    c = make_cell(32'h0, 8'h00, 8'h00);
    ATMcell = c; valid = 1'b1; clav = 1'b1;
    step();
    valid = 1'b0;
    while (ready !== 1'b1 && guard < 200) begin
      if (en === 1'b0) en_low++;
      if (en === 1'b0 && clav === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL basic_octet extra data=%h", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e.d || soc !== e.s) begin failures++; $display("FAIL basic_octet got data=%h soc=%b want data=%h soc=%b", data, soc, e.d, e.s); end
        end
      end
      step(); guard++;
    end
    exp_count++;
    checks += 4;
    if (guard >= 200) begin failures++; $display("FAIL basic_timeout got=%0d cycles want<200", guard); end
    if (en_low != 53) begin failures++; $display("FAIL basic_en_cycles got=%0d want=53", en_low); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing got=%0d left want=0", exp_q.size()); end
    if (tx_count !== 16'(exp_count)) begin failures++; $display("FAIL basic_tx_count got=%0d want=%0d", tx_count, exp_count); end
    exp_q.delete();
    $display("cell basic hdr=00000000 en_low=%0d tx_count=%0d", en_low, tx_count);
  endtask

  task automatic test_idle_hec();
    logic [423:0] c;
    exp_t e;
    int n = 0, guard = 0;
    c = make_cell(32'h0000_0001, 8'hFF, 8'h80);
    ATMcell = c; valid = 1'b1; clav = 1'b1;
    step();
    valid = 1'b0;
    while (ready !== 1'b1 && guard < 200) begin
      if (en === 1'b0 && clav === 1'b1) begin
        checks++;
        if (n == 4) begin
          checks++;
          if (data !== 8'h52) begin failures++; $display("FAIL hec_gen got=%h want=52", data); end
          if (data0 !== c[391:384]) begin failures++; $display("FAIL hec_passthru got=%h want=%h", data0, c[391:384]); end
        end
        if (exp_q.size() == 0) begin failures++; $display("FAIL idle_octet extra data=%h", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e.d || soc !== e.s) begin failures++; $display("FAIL idle_octet%0d got data=%h soc=%b want data=%h soc=%b", n, data, soc, e.d, e.s); end
        end
        n++;
      end
      step(); guard++;
    end
    exp_count++;
    checks += 2;
    if (n != 53) begin failures++; $display("FAIL idle_transfers got=%0d want=53", n); end
    if (tx_count !== 16'(exp_count)) begin failures++; $display("FAIL idle_tx_count got=%0d want=%0d", tx_count, exp_count); end
    exp_q.delete();
    $display("cell idle hdr=00000001 tx_count=%0d", tx_count);
  endtask

  task automatic test_stall();
    logic [423:0] c;
    exp_t e;
    int n = 0, guard = 0, stalls = 0, held = 0, en_low = 0;
    c = make_cell(32'hA5C3_1E70, 8'h00, 8'h20);
    ATMcell = c; valid = 1'b1; clav = 1'b1;
    step();
    valid = 1'b0;
    while (ready !== 1'b1 && guard < 200) begin
      clav = (n == 20 && stalls < 3) ? 1'b0 : 1'b1;
      if (clav == 1'b0) stalls++;
      if (en === 1'b0) en_low++;
      if (n == 20 && en === 1'b0 && data === c[263:256]) held++;
      if (en === 1'b0 && clav === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stall_octet extra data=%h", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e.d || soc !== e.s) begin failures++; $display("FAIL stall_octet%0d got data=%h soc=%b want data=%h soc=%b", n, data, soc, e.d, e.s); end
        end
        n++;
      end
      step(); guard++;
    end
    clav = 1'b1;
    exp_count++;
    checks += 4;
    if (held != 4) begin failures++; $display("FAIL stall_hold got=%0d want=4", held); end
    if (en_low != 56) begin failures++; $display("FAIL stall_cycles got=%0d want=56", en_low); end
    if (n != 53) begin failures++; $display("FAIL stall_transfers got=%0d want=53", n); end
    if (tx_count !== 16'(exp_count)) begin failures++; $display("FAIL stall_tx_count got=%0d want=%0d", tx_count, exp_count); end
    exp_q.delete();
    $display("cell stall hdr=a5c31e70 en_low=%0d tx_count=%0d", en_low, tx_count);
  endtask

  task automatic test_back_to_back();
    logic [423:0] a, b, j;
    exp_t e;
    int acc = 0, t = 0, s1 = -1, s2 = -1, gap = 0, nb = 0, guard = 0;
    a = make_cell(32'h1234_5678, 8'h00, 8'h10);
    b = make_cell(32'h0ABC_DEF1, 8'h00, 8'h40);
    j = make_cell(32'hFFFF_FFFF, 8'hAA, 8'hC0);
    ATMcell = a; valid = 1'b1; clav = 1'b1;
    while (guard < 300 && !(acc == 2 && ready === 1'b1)) begin
      if (soc === 1'b1 && en === 1'b0) begin
        if (s1 < 0) s1 = t; else if (s2 < 0) s2 = t;
      end
      if (s1 >= 0 && s2 < 0 && en === 1'b1) gap++;
      if (en === 1'b0 && clav === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL b2b_octet extra data=%h", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e.d || soc !== e.s) begin failures++; $display("FAIL b2b_octet got data=%h soc=%b want data=%h soc=%b", data, soc, e.d, e.s); end
        end
        if (acc == 2) nb++;
      end
      step(); t++; guard++;
      if (acc_flag) begin
        acc++;
        if (acc == 1) ATMcell = b;
      end
      if (acc == 2) begin
        // Toggle valid with a junk cell while busy; it must be ignored.
        if (nb < 40) begin
          valid = ~valid;
          ATMcell = valid ? j : b;
        end else begin
          valid = 1'b0;
        end
      end
    end
    valid = 1'b0;
    exp_count += 2;
    checks += 5;
    if (guard >= 300) begin failures++; $display("FAIL b2b_timeout got=%0d cycles want<300", guard); end
    if (s2 - s1 != 54) begin failures++; $display("FAIL b2b_soc_spacing got=%0d want=54", s2 - s1); end
    if (gap != 1) begin failures++; $display("FAIL b2b_gap got=%0d want=1", gap); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing got=%0d left want=0", exp_q.size()); end
    if (tx_count !== 16'(exp_count)) begin failures++; $display("FAIL b2b_tx_count got=%0d want=%0d", tx_count, exp_count); end
    exp_q.delete();
    $display("cells back_to_back accepted=%0d soc_spacing=%0d gap=%0d tx_count=%0d", acc, s2 - s1, gap, tx_count);
  endtask

  task automatic test_reset_mid();
    logic [423:0] c;
    exp_t e;
    int n = 0, guard = 0;
    c = make_cell(32'h5555_AAAA, 8'h00, 8'h60);
    ATMcell = c; valid = 1'b1; clav = 1'b1;
    step();
    valid = 1'b0;
    while (n < 30 && guard < 200) begin
      if (en === 1'b0 && clav === 1'b1) begin
        if (exp_q.size() != 0) e = exp_q.pop_front();
        n++;
      end
      step(); guard++;
    end
    #5 reset = 1'b1;
    #1;
    checks += 2;
    if (en !== 1'b1) begin failures++; $display("FAIL midreset_en got=%b want=1", en); end
    if (soc !== 1'b0) begin failures++; $display("FAIL midreset_soc got=%b want=0", soc); end
    exp_q.delete();
    exp_count = 0;
    repeat (2) @(posedge clk_in);
    #3 reset = 1'b0;
    @(posedge clk_in); #1;
    checks += 2;
    if (ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b want=1", ready); end
    if (tx_count !== 16'h0) begin failures++; $display("FAIL midreset_tx_count got=%0d want=0", tx_count); end
    $display("reset mid-cell at octet %0d en=%b tx_count=%0d", n, en, tx_count);
    c = make_cell(32'h0F0F_3C3C, 8'h00, 8'h90);
    ATMcell = c; valid = 1'b1;
    step();
    valid = 1'b0;
    n = 0; guard = 0;
    while (ready !== 1'b1 && guard < 200) begin
      if (en === 1'b0 && clav === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL postreset_octet extra data=%h", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e.d || soc !== e.s) begin failures++; $display("FAIL postreset_octet%0d got data=%h soc=%b want data=%h soc=%b", n, data, soc, e.d, e.s); end
        end
        n++;
      end
      step(); guard++;
    end
    exp_count++;
    checks++;
    if (tx_count !== 16'(exp_count)) begin failures++; $display("FAIL postreset_tx_count got=%0d want=%0d", tx_count, exp_count); end
    exp_q.delete();
    $display("cell post_reset hdr=0f0f3c3c transfers=%0d tx_count=%0d", n, tx_count);
  endtask

  task automatic test_wrap();
    logic [423:0] c;
    exp_t e;
    int guard = 0;
    force dut.tx_count_reg = 16'hFFFF;
    #2 release dut.tx_count_reg;
    @(posedge clk_in); #1;
    checks++;
    if (tx_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h want=ffff", tx_count); end
    c = make_cell(32'hC0DE_0042, 8'h00, 8'hD0);
    ATMcell = c; valid = 1'b1; clav = 1'b1;
    step();
    valid = 1'b0;
    while (ready !== 1'b1 && guard < 200) begin
      if (en === 1'b0 && clav === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL wrap_octet extra data=%h", data); end
        else begin
          e = exp_q.pop_front();
          if (data !== e.d || soc !== e.s) begin failures++; $display("FAIL wrap_octet got data=%h soc=%b want data=%h soc=%b", data, soc, e.d, e.s); end
        end
      end
      step(); guard++;
    end
    checks++;
    if (tx_count !== 16'h0000) begin failures++; $display("FAIL wrap_tx_count got=%h want=0000", tx_count); end
    exp_q.delete();
    $display("cell wrap hdr=c0de0042 tx_count=%h", tx_count);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_hec();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute backstop so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=timeout want=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/utopia1_atm_tx.md
# utopia1_atm_tx

Transmit side of the UTOPIA level-1 ATM-layer port. It accepts one complete UNI cell from the switch core through a valid/ready handshake and buffers it. It then serialises the cell as 53 octets onto the PHY-facing UTOPIA bus, pacing on the PHY's cell-available flag. It optionally regenerates the HEC octet and counts transmitted cells.

## Interface
- `GEN_HEC`, default 1: 1 = replace the HEC octet with a computed HEC; 0 = send the HEC field as received.
- `clk_in`  in  1  25 MHz clock. All logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clk_out`  out  1  equals `clk_in` (continuous assign).
- `ATMcell`  in  424  UNI cell from the core, `uniType` layout. Sampled only at the accept edge.
- `valid`  in  1  core offers `ATMcell`.
- `ready`  out  1  block can accept a cell.
- `data`  out  8  UTOPIA TxData.
- `soc`  out  1  start of cell. High with octet 0 only.
- `en`  out  1  TxEnb, active-low. 0 means `data` is presented.
- `clav`  in  1  PHY TxClav. 1 means the PHY takes the presented octet.
- `tx_count`  out  16  cells fully transmitted. Wraps modulo 2^16.

## Operation
- One clock domain; reset is asynchronous and active-high.
- Reset values: state IDLE, `ready`=1, `en`=1, `soc`=0, `data`=0, `tx_count`=0, octet index 0, buffer contents don't-care.
- States:
  - IDLE: `ready`=1, `en`=1. At an edge with `valid`=1:
    - latch `ATMcell` into the buffer; this is the accept edge;
    - `ready`<=0, `data`<=octet 0, `soc`<=1, `en`<=0, index<=0;
    - go to SEND.
  - SEND: octet k transfers at an edge where `en`=0 and `clav`=1.
    - If k<52 at the transfer edge: index<=k+1, `data`<=octet k+1, `soc`<=0.
    - If k=52 at the transfer edge: `en`<=1, `data`<=0, `ready`<=1, `tx_count`<=`tx_count`+1, go to IDLE.
    - If `clav`=0: `data`, `soc`, `en` and index hold (stall, unbounded).
- Octet order:
  - 0 = {GFC, VPI[7:4]}
  - 1 = {VPI[3:0], VCI[15:12]}
  - 2 = VCI[11:4]
  - 3 = {VCI[3:0], CLP, PT}
  - 4 = HEC
  - 5..52 = Payload[0..47]
- HEC with `GEN_HEC`=1: CRC-8, generator x^8+x^2+x+1, initial value 0, over octets 0..3 MSB first, result XOR 0x55. Computed from the buffer, combinationally from the latched header. The header field is ignored.
- `valid` while `ready`=0 is ignored. The core must hold `valid` and `ATMcell` until it sees `ready`=1 at an edge.
- Reset mid-cell: the cell is abandoned, `en`=1 and `soc`=0 immediately (asynchronous). No partial-cell resumption.

## Timing
- Octet 0 appears on `data` in the cycle after the accept edge.
- With `clav` held 1: 53 consecutive cycles with `en`=0, then `ready` returns 1 in the cycle after the octet-52 transfer.
- Back-to-back cells: minimum one cycle of `en`=1 between cells. Accept to next accept takes 54 cycles.
- Each `clav`=0 edge during SEND adds exactly one cycle.
- `tx_count` updates at the octet-52 transfer edge and is visible the next cycle.

## Structure
- Shared package (with the receive side) holds:
  - `uniType`/`nniType` cell typedefs;
  - constants `CELL_OCTETS`=53, `HDR_OCTETS`=5, `PAYLOAD_OCTETS`=48;
  - HEC polynomial 8'h07 and coset 8'h55.
- State enum is local to the module: IDLE, SEND.
- Sub-module `atm_hec_gen`: combinational, 32-bit header in, 8-bit HEC out. The receive-side HEC checker reuses it.

## Test plan
- Header 00 00 00 00, payload 0x00..0x2F, `clav`=1, `GEN_HEC`=1:
  - octets 00 00 00 00 55 00 01 .. 2F;
  - `soc` high exactly with octet 0;
  - `en`=0 for 53 cycles;
  - `tx_count`=1.
- Idle-cell header 00 00 00 01, HEC field 0xFF, `GEN_HEC`=1: octet 4 = 0x52. With `GEN_HEC`=0: octet 4 = 0xFF.
- `clav` dropped for 3 cycles at octet 20:
  - octet 20 is held on `data` with `en`=0 for 4 cycles;
  - no octet is duplicated or skipped;
  - the cell completes in 56 cycles.
- Two cells with `valid` held continuously: one `en`=1 gap cycle between cells, second `soc` at cycle 54, `tx_count`=2; a `valid` toggle during SEND has no effect.
- `reset` asserted at octet 30:
  - `en`=1 and `soc`=0 immediately;
  - after release: `ready`=1, `tx_count`=0;
  - the next cell starts from octet 0.
- Preload `tx_count`=16'hFFFF by sending 65535 cells, or force it to 16'hFFFF; one further cell gives `tx_count`=16'h0000.
